// File: rtl/pipe_hazard_ctrl.sv
// Hazard and halt controller for a five-stage pipeline: load-use stalls,
// branch/jump flushes, halt/resume FSM and run/stall/flush counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        halt_req,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_en,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // state | meaning
  // RUN   | pipeline advancing, hazards resolved each cycle
  // HALT  | halting syscall frozen in WB, waiting for a go rising edge
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0] state;
  logic       go_q;
  logic       resume_q;
  logic       load_use;
  logic       freeze;
  logic       go_rise;
  logic       sel_stall;
  logic       sel_flush;

  assign load_use = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // halt_req is still asserted in the first cycle after resume; ignore it there
  assign freeze  = (state == HALT) | (halt_req & ~resume_q);
  assign go_rise = go & ~go_q;
  assign halted  = (state == HALT);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    sel_stall  = 1'b0;
    sel_flush  = 1'b0;
    if (freeze) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      sel_flush  = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      sel_stall  = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
      sel_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      go_q      <= 1'b0;
      resume_q  <= 1'b0;
      cycle_cnt <= 32'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      go_q <= go;
      if (state == HALT) begin
        resume_q <= go_rise;
        if (go_rise) state <= RUN;
      end else begin
        resume_q <= 1'b0;
        if (freeze) begin
          state <= HALT;
        end else begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (sel_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          if (sel_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

  typedef struct {
    bit       rst, go, halt_req, urs, urt, rw, mtr, jump, br;
    bit [4:0] rs, rt, rd;
  } stim_t;

  typedef struct {
    bit        pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted;
    bit [31:0] cyc;
    bit [15:0] stall, flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst, go, halt_req, id_uses_rs, id_uses_rt, ex_regwrite, ex_memtoreg;
  logic id_jump, ex_branch_taken;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, halted;
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass = 0;
  exp_t exp_q[$];

  // reference state
  bit        m_halt, m_resume, m_goq;
  bit [31:0] m_cyc;
  int        m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .halt_req(halt_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_en(pipe_en), .halted(halted), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_en", pc_en, e.pc_en);
        check("ifid_en", ifid_en, e.ifid_en);
        check("ifid_flush", ifid_flush, e.ifid_flush);
        check("idex_flush", idex_flush, e.idex_flush);
        check("pipe_en", pipe_en, e.pipe_en);
        check("halted", halted, e.halted);
        check("cycle_cnt", cycle_cnt, e.cyc);
        check("stall_cnt", stall_cnt, e.stall);
        check("flush_cnt", flush_cnt, e.flush);
      end
    end
  end

  // Applies one cycle of stimulus at posedge+1, queues the expected outputs
  // for this cycle, advances the model across the next edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, frz, rise;
    byte  rule;
    rst = s.rst; go = s.go; halt_req = s.halt_req;
    id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
    ex_rd = s.rd; ex_regwrite = s.rw; ex_memtoreg = s.mtr;
    id_jump = s.jump; ex_branch_taken = s.br;

    lu  = s.mtr && s.rw && s.rd != 0 &&
          ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    frz = m_halt || (s.halt_req && !m_resume);
    if (frz) rule = "a";
    else if (s.br) rule = "b";
    else if (lu) rule = "c";
    else if (s.jump) rule = "d";
    else rule = "e";

    e.pc_en      = (rule == "b" || rule == "d" || rule == "e");
    e.ifid_en    = e.pc_en;
    e.pipe_en    = (rule != "a");
    e.ifid_flush = (rule == "b" || rule == "d");
    e.idex_flush = (rule == "b" || rule == "c");
    e.halted     = m_halt;
    e.cyc        = m_cyc;
    e.stall      = 16'(m_stall);
    e.flush      = 16'(m_flush);
    exp_q.push_back(e);

    rise = s.go && !m_goq;
    if (s.rst) begin
      m_halt = 0; m_resume = 0; m_goq = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_halt) begin
        m_resume = rise;
        if (rise) m_halt = 0;
      end else begin
        m_resume = 0;
        if (rule == "a") m_halt = 1;
        else begin
          m_cyc = m_cyc + 1;
          if (rule == "c") m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
          if (rule == "b" || rule == "d") m_flush = (m_flush >= 65535) ? 65535 : m_flush + 1;
        end
      end
      m_goq = s.go;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  initial begin
    stim_t s;
    bit    go_lvl;
    rst = 1; go = 0; halt_req = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = 0; ex_regwrite = 0; ex_memtoreg = 0; id_jump = 0; ex_branch_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    m_halt = 0; m_resume = 0; m_goq = 0; m_cyc = 0; m_stall = 0; m_flush = 0;

    // idle after reset
    repeat (2) step(idle());

    // load-use on rs, then same with ex_rd = 0
    s = idle(); s.mtr = 1; s.rw = 1; s.rd = 8; s.rs = 8; s.urs = 1;
    step(s);
    step(idle());
    check("stall_after_lu", stall_cnt, 1);
    s.rd = 0; s.rs = 0;
    step(s);
    // load-use on rt with a jump held under the stall
    s = idle(); s.mtr = 1; s.rw = 1; s.rd = 5; s.rt = 5; s.urt = 1; s.jump = 1;
    step(s);
    s = idle(); s.jump = 1;
    step(s);

    // branch over load-use and jump
    s = idle(); s.br = 1; s.jump = 1; s.mtr = 1; s.rw = 1; s.rd = 3; s.rs = 3; s.urs = 1;
    step(s);
    step(idle());

    // halt with go held, then resume with halt_req still high for one cycle
    s = idle(); s.halt_req = 1; s.go = 1;
    repeat (4) step(s);
    check("halted_go_held", halted, 1);
    s.go = 0;
    repeat (2) step(s);
    s.go = 1;
    step(s);
    step(s);
    check("resumed", halted, 0);
    s = idle(); s.go = 1;
    repeat (2) step(s);

    // reset while halted
    s = idle(); s.halt_req = 1;
    repeat (3) step(s);
    s.rst = 1;
    step(s);
    check("rst_mid_halt", halted, 0);
    check("rst_cyc", cycle_cnt, 0);
    step(idle());

    // randomized traffic
    go_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) go_lvl = ~go_lvl;
      s.rst      = ($urandom_range(0, 299) == 0);
      s.go       = go_lvl;
      s.halt_req = ($urandom_range(0, 19) == 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.urs      = 1'($urandom);
      s.urt      = 1'($urandom);
      s.rw       = 1'($urandom);
      s.mtr      = 1'($urandom);
      s.jump     = ($urandom_range(0, 3) == 0);
      s.br       = ($urandom_range(0, 5) == 0);
      step(s);
    end

    // saturation of flush_cnt
    s = idle(); s.rst = 1;
    step(s);
    s = idle(); s.jump = 1;
    repeat (70000) step(s);
    check("flush_sat", flush_cnt, 16'hFFFF);
    check("cyc_70000", cycle_cnt, 70000);
    step(idle());

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The module SHALL have these inputs, one per line:
- go  input  1  debounced resume button, level.
- halt_req  input  1  halting syscall currently in WB.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_regwrite  input  1  EX instruction writes a register.
- ex_memtoreg  input  1  EX instruction is a load.
- id_jump  input  1  j, jal or jr in ID.
- ex_branch_taken  input  1  beq/bne/blez resolved taken in EX.
REQ-003 The module SHALL have these outputs, one per line:
- pc_en  output  1  PC load enable.
- ifid_en  output  1  IF/ID register enable.
- ifid_flush  output  1  clear IF/ID to a bubble.
- idex_flush  output  1  clear ID/EX to a bubble.
- pipe_en  output  1  enable for ID/EX, EX/MEM and MEM/WB.
- halted  output  1  state is HALT.
- cycle_cnt  output  32  count of run cycles.
- stall_cnt  output  16  count of load-use stalls.
- flush_cnt  output  16  count of flush events.

Function
REQ-004 The FSM SHALL have two states, RUN and HALT, and halted SHALL equal (state==HALT).
REQ-005 load_use SHALL be ex_memtoreg & ex_regwrite & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-006 Outputs SHALL be combinational from state and inputs, using the first matching rule in this priority order:
- (a) HALT, or RUN with halt_req=1: pc_en=0, ifid_en=0, pipe_en=0, ifid_flush=0, idex_flush=0.
- (b) ex_branch_taken=1: pc_en=1, ifid_en=1, pipe_en=1, ifid_flush=1, idex_flush=1.
- (c) load_use=1: pc_en=0, ifid_en=0, pipe_en=1, idex_flush=1, ifid_flush=0.
- (d) id_jump=1: pc_en=1, ifid_en=1, pipe_en=1, ifid_flush=1, idex_flush=0.
- (e) otherwise: pc_en=1, ifid_en=1, pipe_en=1, both flushes 0.
REQ-007 A taken branch SHALL suppress a simultaneous load-use stall and jump flush, because the younger instructions are discarded.
REQ-008 A load-use stall SHALL last exactly one cycle, since the load leaves EX on the next edge; id_jump held under a stall SHALL be honoured in the cycle after the stall.
REQ-009 RUN SHALL go to HALT on the clock edge where halt_req=1; the halting instruction SHALL be frozen in WB and SHALL NOT be re-committed.
REQ-010 A go_q register SHALL hold the previous value of go; a rising edge SHALL be go & ~go_q.
REQ-011 HALT SHALL go to RUN on the edge where a rising edge of go is seen; a go held high through entry into HALT SHALL NOT resume.
REQ-012 In the resume cycle, halt_req remains high (the syscall is still in WB), so outputs SHALL follow rules (b)-(e) for that one cycle; halt_req SHALL be ignored in the first RUN cycle after HALT.
REQ-013 In RUN, cycle_cnt SHALL increment by 1 on every edge except the edge that enters HALT, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-014 stall_cnt SHALL increment on every cycle selected by rule (c) and SHALL saturate at 0xFFFF.
REQ-015 flush_cnt SHALL increment on every cycle selected by rule (b) or (d), by 1 per cycle, and SHALL saturate at 0xFFFF.
REQ-016 All counters SHALL hold their value in HALT.

Reset
REQ-017 rst=1 at a clock edge SHALL set state=RUN, go_q=0, cycle_cnt=0, stall_cnt=0 and flush_cnt=0.
REQ-018 After reset, with all inputs 0, the outputs SHALL be pc_en=1, ifid_en=1, pipe_en=1, flushes=0 and halted=0.
REQ-019 rst SHALL take priority over every other input, including during HALT and during a stall; it SHALL act within the same edge.

Verification
REQ-020 Load-use: ex_memtoreg=1, ex_regwrite=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 in that cycle; stall_cnt=1 afterwards; same stimulus with ex_rd=0 -> no stall.
REQ-021 Branch over load-use: ex_branch_taken=1 together with a load_use condition and id_jump=1 -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged; flush_cnt +1.
REQ-022 Halt/resume: halt_req=1 with go=1 held -> halted=1 next cycle and stays 1 while go is held; go 0->1 -> RUN next cycle; halt_req held high for one more cycle causes no re-halt; cycle_cnt frozen throughout HALT.
REQ-023 Saturation: 70000 consecutive jump cycles -> flush_cnt=0xFFFF; cycle_cnt=70000.
REQ-024 Reset mid-HALT: rst=1 while halted=1 -> halted=0 and all counters 0 after that edge; pc_en=1 in the following cycle.
